frogger_obstacle_mover: RTL and testbench

- Produces the car and log positions consumed by the collision checker.
- Moves five car lanes and three log lanes horizontally at lane-specific speeds on the 14-tile playfield, with wrap-around.
- Emits a one-cycle step pulse per log lane so the frog controller can carry a frog riding that log.
- Sits between the game-state controller (enable, level, restart) and the collision/render blocks.

---
 rtl/frogger_pkg.sv | 36 +++
 rtl/frogger_lane_mover.sv | 56 +++++
 rtl/frogger_obstacle_mover.sv | 115 +++++++++++
 tb/tb_frogger_obstacle_mover.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared playfield constants for the obstacle lanes: lane rows, start columns,
// step divisors, directions and the wrap-around step helper.
package frogger_pkg;

  localparam int c_GAME_WIDTH = 14;
  localparam int c_NUM_CARS   = 5;
  localparam int c_NUM_LOGS   = 3;

  localparam logic [5:0] c_X_MAX = 6'(c_GAME_WIDTH - 1);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Index 0 is lane 1 in every table below.
  localparam logic [c_NUM_CARS-1:0][5:0] c_CAR_Y      = {6'd11, 6'd10, 6'd9, 6'd8, 6'd7};
  localparam logic [c_NUM_LOGS-1:0][5:0] c_LOG_Y      = {6'd3, 6'd2, 6'd1};
  localparam logic [c_NUM_CARS-1:0][5:0] c_CAR_INIT_X = {6'd2, 6'd9, 6'd4, 6'd13, 6'd0};
  localparam logic [c_NUM_LOGS-1:0][5:0] c_LOG_INIT_X = {6'd12, 6'd7, 6'd2};
  localparam logic [c_NUM_CARS-1:0][1:0] c_CAR_DIV    = {2'd1, 2'd2, 2'd3, 2'd2, 2'd1};
  localparam logic [c_NUM_LOGS-1:0][1:0] c_LOG_DIV    = {2'd2, 2'd3, 2'd2};
  localparam logic [c_NUM_CARS-1:0]      c_CAR_DIR    = 5'b10101;
  localparam logic [c_NUM_LOGS-1:0]      c_LOG_DIR    = 3'b111;

  function automatic logic [5:0] wrapStep(input logic [5:0] x, input dir_e dir);
    logic [5:0] nextX;
    if (dir == DIR_RIGHT) begin
      nextX = (x >= c_X_MAX) ? 6'd0 : x + 6'd1;
    end else begin
      nextX = (x == 6'd0) ? c_X_MAX : x - 6'd1;
    end
    return nextX;
  endfunction

endpackage

// File: rtl/frogger_lane_mover.sv
// One obstacle lane: divides the shared base tick, moves its X with
// wrap-around and raises a one-cycle step pulse alongside each new X.
module frogger_lane_mover
  import frogger_pkg::*;
#(
  parameter logic [5:0] P_INIT_X = 6'd0,
  parameter logic [1:0] P_DIV    = 2'd1,
  parameter dir_e       P_DIR    = DIR_RIGHT
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Tick,
  input  logic       i_Restart,
  output logic [5:0] o_X,
  output logic       o_Step
);

  logic [1:0] cnt_q, cnt_d;
  logic [5:0] x_q, x_d;
  logic       step_q, step_d;

  // Restart wins over a coincident tick so the lane comes back cleanly.
  always_comb begin
    cnt_d  = cnt_q;
    x_d    = x_q;
    step_d = 1'b0;
    if (i_Restart) begin
      cnt_d = 2'd0;
      x_d   = P_INIT_X;
    end else if (i_Tick) begin
      if (cnt_q == P_DIV - 2'd1) begin
        cnt_d  = 2'd0;
        x_d    = wrapStep(x_q, P_DIR);
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      cnt_q  <= 2'd0;
      x_q    <= P_INIT_X;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      step_q <= step_d;
    end
  end

  assign o_X    = x_q;
  assign o_Step = step_q;

endmodule

// File: rtl/frogger_obstacle_mover.sv
// Level-scaled base-tick prescaler driving five car lanes and three log lanes;
// log step pulses let the frog controller carry a riding frog.
module frogger_obstacle_mover
  import frogger_pkg::*;
#(
  parameter int unsigned c_BASE_DIV = 12_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Enable,
  input  logic [1:0] i_Level,
  input  logic       i_Restart,
  output logic [5:0] o_Car_X_1,
  output logic [5:0] o_Car_X_2,
  output logic [5:0] o_Car_X_3,
  output logic [5:0] o_Car_X_4,
  output logic [5:0] o_Car_X_5,
  output logic [5:0] o_Car_Y_1,
  output logic [5:0] o_Car_Y_2,
  output logic [5:0] o_Car_Y_3,
  output logic [5:0] o_Car_Y_4,
  output logic [5:0] o_Car_Y_5,
  output logic [5:0] o_Log_X_1,
  output logic [5:0] o_Log_X_2,
  output logic [5:0] o_Log_X_3,
  output logic [5:0] o_Log_Y_1,
  output logic [5:0] o_Log_Y_2,
  output logic [5:0] o_Log_Y_3,
  output logic [2:0] o_Log_Step
);

  localparam logic [23:0] c_DIV24 = 24'(c_BASE_DIV);

  logic [23:0] period, periodM1;
  logic [23:0] preCount_q, preCount_d;
  logic        baseTick;

  logic [5:0]            carX [c_NUM_CARS];
  logic [5:0]            logX [c_NUM_LOGS];
  logic [c_NUM_CARS-1:0] unusedCarStep;
  logic [c_NUM_LOGS-1:0] logStep;

  // A period that shifts down to zero is treated as one tick per enabled cycle;
  // the >= compare lets a mid-count level raise tick right away.
  always_comb begin
    period     = c_DIV24 >> i_Level;
    periodM1   = (period == 24'd0) ? 24'd0 : period - 24'd1;
    baseTick   = i_Enable && !i_Restart && (preCount_q >= periodM1);
    preCount_d = preCount_q;
    if (i_Restart) begin
      preCount_d = 24'd0;
    end else if (i_Enable) begin
      preCount_d = baseTick ? 24'd0 : preCount_q + 24'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      preCount_q <= 24'd0;
    end else begin
      preCount_q <= preCount_d;
    end
  end

  for (genvar i = 0; i < c_NUM_CARS; i++) begin : g_car
    frogger_lane_mover #(
      .P_INIT_X (c_CAR_INIT_X[i]),
      .P_DIV    (c_CAR_DIV[i]),
      .P_DIR    (c_CAR_DIR[i] ? DIR_RIGHT : DIR_LEFT)
    ) u_lane (
      .i_Clk     (i_Clk),
      .i_Rst_N   (i_Rst_N),
      .i_Tick    (baseTick),
      .i_Restart (i_Restart),
      .o_X       (carX[i]),
      .o_Step    (unusedCarStep[i])
    );
  end

  for (genvar i = 0; i < c_NUM_LOGS; i++) begin : g_log
    frogger_lane_mover #(
      .P_INIT_X (c_LOG_INIT_X[i]),
      .P_DIV    (c_LOG_DIV[i]),
      .P_DIR    (c_LOG_DIR[i] ? DIR_RIGHT : DIR_LEFT)
    ) u_lane (
      .i_Clk     (i_Clk),
      .i_Rst_N   (i_Rst_N),
      .i_Tick    (baseTick),
      .i_Restart (i_Restart),
      .o_X       (logX[i]),
      .o_Step    (logStep[i])
    );
  end

  assign o_Car_X_1 = carX[0];
  assign o_Car_X_2 = carX[1];
  assign o_Car_X_3 = carX[2];
  assign o_Car_X_4 = carX[3];
  assign o_Car_X_5 = carX[4];
  assign o_Log_X_1 = logX[0];
  assign o_Log_X_2 = logX[1];
  assign o_Log_X_3 = logX[2];

  assign o_Car_Y_1 = c_CAR_Y[0];
  assign o_Car_Y_2 = c_CAR_Y[1];
  assign o_Car_Y_3 = c_CAR_Y[2];
  assign o_Car_Y_4 = c_CAR_Y[3];
  assign o_Car_Y_5 = c_CAR_Y[4];
  assign o_Log_Y_1 = c_LOG_Y[0];
  assign o_Log_Y_2 = c_LOG_Y[1];
  assign o_Log_Y_3 = c_LOG_Y[2];

  assign o_Log_Step = logStep;

endmodule

// File: tb/tb_frogger_obstacle_mover.sv
// Directed table of per-cycle expectations for a fast-prescaler mover, plus
// hand-written wrap, level-change and async-reset sequences.
module tb_frogger_obstacle_mover;

  typedef struct {
    int         n;
    logic       en;
    logic       rs;
    logic [5:0] car [5];
    logic [5:0] lg  [3];
    logic [2:0] step;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  logic en, rs, en16, rs16;
  logic [1:0] lvl, lvl16;

  logic [5:0] carX [5];
  logic [5:0] carY [5];
  logic [5:0] logX [3];
  logic [5:0] logY [3];
  logic [2:0] logStep;

  logic [5:0] carX16 [5];
  logic [5:0] carY16 [5];
  logic [5:0] logX16 [3];
  logic [5:0] logY16 [3];
  logic [2:0] logStep16;

  int errors = 0;
  int checks = 0;

  vec_t vecs [18];

  always #5 clk = ~clk;

  frogger_obstacle_mover #(.c_BASE_DIV(4)) dut (
    .i_Clk(clk), .i_Rst_N(rstN), .i_Enable(en), .i_Level(lvl), .i_Restart(rs),
    .o_Car_X_1(carX[0]), .o_Car_X_2(carX[1]), .o_Car_X_3(carX[2]),
    .o_Car_X_4(carX[3]), .o_Car_X_5(carX[4]),
    .o_Car_Y_1(carY[0]), .o_Car_Y_2(carY[1]), .o_Car_Y_3(carY[2]),
    .o_Car_Y_4(carY[3]), .o_Car_Y_5(carY[4]),
    .o_Log_X_1(logX[0]), .o_Log_X_2(logX[1]), .o_Log_X_3(logX[2]),
    .o_Log_Y_1(logY[0]), .o_Log_Y_2(logY[1]), .o_Log_Y_3(logY[2]),
    .o_Log_Step(logStep)
  );

  frogger_obstacle_mover #(.c_BASE_DIV(16)) dut16 (
    .i_Clk(clk), .i_Rst_N(rstN), .i_Enable(en16), .i_Level(lvl16), .i_Restart(rs16),
    .o_Car_X_1(carX16[0]), .o_Car_X_2(carX16[1]), .o_Car_X_3(carX16[2]),
    .o_Car_X_4(carX16[3]), .o_Car_X_5(carX16[4]),
    .o_Car_Y_1(carY16[0]), .o_Car_Y_2(carY16[1]), .o_Car_Y_3(carY16[2]),
    .o_Car_Y_4(carY16[3]), .o_Car_Y_5(carY16[4]),
    .o_Log_X_1(logX16[0]), .o_Log_X_2(logX16[1]), .o_Log_X_3(logX16[2]),
    .o_Log_Y_1(logY16[0]), .o_Log_Y_2(logY16[1]), .o_Log_Y_3(logY16[2]),
    .o_Log_Step(logStep16)
  );

  function automatic vec_t mkVec(input int n, input logic e, input logic r,
                                 input int c1, input int c2, input int c3, input int c4,
                                 input int c5, input int l1, input int l2, input int l3,
                                 input logic [2:0] s);
    vec_t v;
    v.n = n; v.en = e; v.rs = r;
    v.car[0] = 6'(c1); v.car[1] = 6'(c2); v.car[2] = 6'(c3);
    v.car[3] = 6'(c4); v.car[4] = 6'(c5);
    v.lg[0] = 6'(l1); v.lg[1] = 6'(l2); v.lg[2] = 6'(l3);
    v.step = s;
    return v;
  endfunction

  task automatic applyStimulus(input logic e, input logic r, input logic [1:0] l);
    en  = e;
    rs  = r;
    lvl = l;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkInitial(input string tag);
    checkOutput({tag, " car1"}, carX[0], 0);
    checkOutput({tag, " car2"}, carX[1], 13);
    checkOutput({tag, " car3"}, carX[2], 4);
    checkOutput({tag, " car4"}, carX[3], 9);
    checkOutput({tag, " car5"}, carX[4], 2);
    checkOutput({tag, " log1"}, logX[0], 2);
    checkOutput({tag, " log2"}, logX[1], 7);
    checkOutput({tag, " log3"}, logX[2], 12);
    checkOutput({tag, " step"}, logStep, 0);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Edge numbers in comments count rising edges after reset release.
    vecs[0]  = mkVec(3,  1, 0, 0, 13, 4, 9, 2, 2, 7, 12, 3'b000); // e1-3
    vecs[1]  = mkVec(1,  1, 0, 1, 13, 4, 9, 3, 2, 7, 12, 3'b000); // e4 first tick
    vecs[2]  = mkVec(3,  1, 0, 1, 13, 4, 9, 3, 2, 7, 12, 3'b000);
    vecs[3]  = mkVec(1,  1, 0, 2, 12, 4, 8, 4, 3, 7, 13, 3'b101); // e8
    vecs[4]  = mkVec(3,  1, 0, 2, 12, 4, 8, 4, 3, 7, 13, 3'b000);
    vecs[5]  = mkVec(1,  1, 0, 3, 12, 5, 8, 5, 3, 8, 13, 3'b010); // e12
    vecs[6]  = mkVec(3,  1, 0, 3, 12, 5, 8, 5, 3, 8, 13, 3'b000);
    vecs[7]  = mkVec(1,  1, 0, 4, 11, 5, 7, 6, 4, 8, 0,  3'b101); // e16 log3 wraps
    vecs[8]  = mkVec(1,  1, 0, 4, 11, 5, 7, 6, 4, 8, 0,  3'b000); // pulse gone
    vecs[9]  = mkVec(10, 0, 0, 4, 11, 5, 7, 6, 4, 8, 0,  3'b000); // freeze, count=1
    vecs[10] = mkVec(2,  1, 0, 4, 11, 5, 7, 6, 4, 8, 0,  3'b000);
    vecs[11] = mkVec(1,  1, 0, 5, 11, 5, 7, 7, 4, 8, 0,  3'b000); // e30 resumed tick
    vecs[12] = mkVec(3,  1, 0, 5, 11, 5, 7, 7, 4, 8, 0,  3'b000);
    vecs[13] = mkVec(1,  1, 0, 6, 10, 6, 6, 8, 5, 9, 1,  3'b111); // e34 all lanes
    vecs[14] = mkVec(3,  1, 0, 6, 10, 6, 6, 8, 5, 9, 1,  3'b000);
    vecs[15] = mkVec(1,  1, 1, 0, 13, 4, 9, 2, 2, 7, 12, 3'b000); // e38 restart on tick
    vecs[16] = mkVec(3,  1, 0, 0, 13, 4, 9, 2, 2, 7, 12, 3'b000);
    vecs[17] = mkVec(1,  1, 0, 1, 13, 4, 9, 3, 2, 7, 12, 3'b000); // e42

    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'd0);
    en16 = 1'b0; rs16 = 1'b0; lvl16 = 2'd0;
    cycles(3);
    checkInitial("reset");
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("carY%0d", i + 1), carY[i], 7 + i);
      checkOutput($sformatf("carY16_%0d", i + 1), carY16[i], 7 + i);
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("logY%0d", i + 1), logY[i], 1 + i);
      checkOutput($sformatf("logY16_%0d", i + 1), logY16[i], 1 + i);
    end
    rstN = 1'b1;

    for (int r = 0; r < 18; r++) begin
      for (int k = 0; k < vecs[r].n; k++) begin
        applyStimulus(vecs[r].en, vecs[r].rs, 2'd0);
        cycles(1);
        for (int c = 0; c < 5; c++)
          checkOutput($sformatf("row%0d.%0d car%0d", r, k, c + 1), carX[c], vecs[r].car[c]);
        for (int g = 0; g < 3; g++)
          checkOutput($sformatf("row%0d.%0d log%0d", r, k, g + 1), logX[g], vecs[r].lg[g]);
        checkOutput($sformatf("row%0d.%0d step", r, k), logStep, vecs[r].step);
      end
    end

    // Car 2 steps left at edge 38+8k; reaches 0 at e142 and wraps at e150.
    applyStimulus(1'b1, 1'b0, 2'd0);
    cycles(99);
    checkOutput("car2 before zero", carX[1], 1);
    cycles(1);
    checkOutput("car2 at zero", carX[1], 0);
    cycles(7);
    checkOutput("car2 holds zero", carX[1], 0);
    cycles(1);
    checkOutput("car2 wrap left", carX[1], 13);

    // Period 16 at level 0; at count 9 switching to level 2 ticks at once.
    en16 = 1'b1; lvl16 = 2'd0;
    cycles(9);
    checkOutput("lvl car1 no tick", carX16[0], 0);
    lvl16 = 2'd2;
    cycles(1);
    checkOutput("lvl immediate tick", carX16[0], 1);
    cycles(3);
    checkOutput("lvl gap", carX16[0], 1);
    cycles(1);
    checkOutput("lvl period4 a", carX16[0], 2);
    cycles(4);
    checkOutput("lvl period4 b", carX16[0], 3);

    #3 rstN = 1'b0;
    #1;
    checkInitial("async");
    checkOutput("async car1_16", carX16[0], 0);
    checkOutput("async log3_16", logX16[2], 12);
    cycles(2);
    rstN = 1'b1;
    cycles(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
